// File: rtl/ps2_arrow_event_queue.sv
// PS/2 arrow-key event parser: decodes E0/F0 prefixed arrow scan codes, tracks held keys,
// suppresses typematic repeats and queues make/break events in a first-word-fall-through FIFO.
module ps2_arrow_event_queue #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_key_pressed,
  input  logic [7:0]        ps2_key_data,
  input  logic              pop,
  input  logic              clear_overflow,
  output logic              evt_valid,
  output logic [7:0]        evt_data,
  output logic [ADDR_W:0]   fifo_count,
  output logic [3:0]        key_held,
  output logic              any_held,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, EXT, EXT_BRK, BRK} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

  state_t            state_reg, state_next;
  logic              is_arrow;
  logic [1:0]        arrow_id;
  logic              make_evt, break_evt;
  logic              push_req, do_push, do_pop, drop;
  logic [7:0]        push_data;
  logic [3:0]        key_held_reg;
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg;
  logic [7:0]        mem [FIFO_DEPTH];

  always_comb begin
    is_arrow = 1'b1;
    arrow_id = 2'd0;
    case (ps2_key_data)
      8'h75:   arrow_id = 2'd0;
      8'h6B:   arrow_id = 2'd1;
      8'h72:   arrow_id = 2'd2;
      8'h74:   arrow_id = 2'd3;
      default: is_arrow = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    make_evt   = 1'b0;
    break_evt  = 1'b0;
    if (ps2_key_pressed) begin
      case (state_reg)
        IDLE: begin
          if (ps2_key_data == 8'hE0)      state_next = EXT;
          else if (ps2_key_data == 8'hF0) state_next = BRK;
          else                            state_next = IDLE;
        end
        EXT: begin
          if (ps2_key_data == 8'hF0)      state_next = EXT_BRK;
          else if (ps2_key_data == 8'hE0) state_next = EXT;
          else begin
            state_next = IDLE;
            make_evt   = is_arrow;
          end
        end
        EXT_BRK: begin
          state_next = IDLE;
          break_evt  = is_arrow;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Repeats of a held key and breaks of an unheld key produce no event.
  assign push_req  = (make_evt && !key_held_reg[arrow_id]) || (break_evt && key_held_reg[arrow_id]);
  assign push_data = {break_evt, 5'b0, arrow_id};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_held
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          key_held_reg[gi] <= 1'b0;
        else if (make_evt && arrow_id == 2'(gi))
          key_held_reg[gi] <= 1'b1;
        else if (break_evt && arrow_id == 2'(gi))
          key_held_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  // A pop on a full FIFO frees the head slot, so a same-edge push is accepted.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push_req && ((count_reg != DEPTH_C) || do_pop);
  assign drop    = push_req && (count_reg == DEPTH_C) && !do_pop;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)      count_next = count_reg + 1'b1;
    else if (do_pop && !do_push) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop)                overflow_reg <= 1'b1;
      else if (clear_overflow) overflow_reg <= 1'b0;
    end
  end

  assign evt_valid  = (count_reg != '0);
  assign evt_data   = evt_valid ? mem[rd_ptr_reg] : 8'h00;
  assign fifo_count = count_reg;
  assign key_held   = key_held_reg;
  assign any_held   = |key_held_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_arrow_event_queue.sv
// Scoreboard bench for ps2_arrow_event_queue: expected events are queued as bytes are sent
// and compared against the FIFO head as entries are popped.
module tb_ps2_arrow_event_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       pop = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic [3:0] fifo_count;
  logic [3:0] key_held;
  logic       any_held;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  ps2_arrow_event_queue #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset),
    .ps2_key_pressed(ps2_key_pressed), .ps2_key_data(ps2_key_data),
    .pop(pop), .clear_overflow(clear_overflow),
    .evt_valid(evt_valid), .evt_data(evt_data), .fifo_count(fifo_count),
    .key_held(key_held), .any_held(any_held), .overflow(overflow)
  );

  always #50 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One strobed byte, optionally with a same-cycle pop; returns on the negedge after the sampling edge.
  task automatic send_now(input logic [7:0] b, input logic p);
    @(negedge clock);
    ps2_key_pressed = 1'b1;
    ps2_key_data    = b;
    pop             = p;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    pop             = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_now(b, 1'b0);
    repeat (2) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 16) begin
      guard++;
      check({tag, " valid"}, 32'(evt_valid), 32'd1);
      check({tag, " data"}, 32'(evt_data), 32'(exp_q.pop_front()));
      pop = 1'b1;
      @(negedge clock);
      pop = 1'b0;
    end
    check({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, " empty"}, 32'(evt_valid), 32'd0);
    check({tag, " count0"}, 32'(fifo_count), 32'd0);
    check({tag, " data0"}, 32'(evt_data), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst valid", 32'(evt_valid), 32'd0);
    check("rst data", 32'(evt_data), 32'd0);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst held", 32'(key_held), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: make up, one-cycle latency
    send(8'hE0);
    send_now(8'h75, 1'b0);
    exp_q.push_back(8'h00);
    check("t1 valid", 32'(evt_valid), 32'd1);
    check("t1 data", 32'(evt_data), 32'h00);
    check("t1 held", 32'(key_held), 32'b0001);
    check("t1 any", 32'(any_held), 32'd1);
    check("t1 count", 32'(fifo_count), 32'd1);
    drain("t1");
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_q.push_back(8'h80);
    check("t1 released", 32'(key_held), 32'b0000);
    drain("t1b");

    // 2: typematic repeats of left collapse to one make
    for (int i = 0; i < 3; i++) begin
      send(8'hE0); send(8'h6B);
      check("t2 held", 32'(key_held), 32'b0010);
    end
    exp_q.push_back(8'h01);
    check("t2 count", 32'(fifo_count), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    exp_q.push_back(8'h81);
    check("t2 released", 32'(key_held), 32'b0000);
    drain("t2");

    // 3: non-arrow traffic and non-extended breaks are ignored
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h12); send(8'hF0); send(8'h74);
    check("t3 count", 32'(fifo_count), 32'd0);
    check("t3 held", 32'(key_held), 32'b0000);
    send(8'hE0); send(8'h72);
    exp_q.push_back(8'h02);
    send(8'hE0); send(8'hF0); send(8'h72);
    exp_q.push_back(8'h82);
    drain("t3");

    // 4: overflow
    for (int k = 0; k < 4; k++) begin
      logic [7:0] code;
      case (k)
        0: code = 8'h75;
        1: code = 8'h6B;
        2: code = 8'h72;
        default: code = 8'h74;
      endcase
      send(8'hE0); send(code);
      exp_q.push_back(8'(k));
      send(8'hE0); send(8'hF0); send(code);
      exp_q.push_back(8'h80 | 8'(k));
    end
    check("t4 count full", 32'(fifo_count), 32'd8);
    check("t4 no ovf yet", 32'(overflow), 32'd0);
    send(8'hE0); send(8'h75);
    check("t4 count", 32'(fifo_count), 32'd8);
    check("t4 overflow", 32'(overflow), 32'd1);
    check("t4 held", 32'(key_held), 32'b0001);
    send(8'hE0); send(8'hF0);
    check("t4 head", 32'(evt_data), 32'(exp_q.pop_front()));
    send_now(8'h75, 1'b1);
    exp_q.push_back(8'h80);
    check("t4 pop+push count", 32'(fifo_count), 32'd8);
    check("t4 ovf kept", 32'(overflow), 32'd1);
    check("t4 held clr", 32'(key_held), 32'b0000);
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    check("t4 ovf cleared", 32'(overflow), 32'd0);
    drain("t4");

    // 5: spurious break, pop on empty, repeated E0
    send(8'hE0); send(8'hF0); send(8'h74);
    check("t5 spurious", 32'(fifo_count), 32'd0);
    pop = 1'b1;
    @(negedge clock);
    pop = 1'b0;
    check("t5 pop empty count", 32'(fifo_count), 32'd0);
    check("t5 pop empty valid", 32'(evt_valid), 32'd0);
    send(8'hE0); send(8'hE0); send(8'h72);
    exp_q.push_back(8'h02);
    check("t5 held down", 32'(key_held), 32'b0100);
    drain("t5");
    send(8'hE0); send(8'hF0); send(8'h72);
    exp_q.push_back(8'h82);
    drain("t5b");

    // 6: reset mid-prefix
    send(8'hE0); send(8'h74);
    check("t6 pre valid", 32'(evt_valid), 32'd1);
    check("t6 pre held", 32'(key_held), 32'b1000);
    send(8'hE0);
    reset = 1'b1;
    #1;
    check("t6 rst valid", 32'(evt_valid), 32'd0);
    check("t6 rst data", 32'(evt_data), 32'd0);
    check("t6 rst count", 32'(fifo_count), 32'd0);
    check("t6 rst held", 32'(key_held), 32'd0);
    check("t6 rst any", 32'(any_held), 32'd0);
    check("t6 rst ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    send(8'h75);
    check("t6 no event", 32'(fifo_count), 32'd0);
    check("t6 no held", 32'(key_held), 32'd0);
    send(8'hE0); send(8'h75);
    exp_q.push_back(8'h00);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
